// File: rtl/gb_mailbox.sv
// Ghostbus mailbox: TX FIFO fed by host DATA writes, optional RX FIFO drained by DATA reads,
// plus STATUS/CTRL/SCRATCH. Optional RX path is built when GB_MAILBOX_RXFIFO_EN is defined.
module gb_mailbox #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        gb_clk,
    input  logic        gb_rst,
    input  logic [23:0] gb_addr,
    input  logic [31:0] gb_wdata,
    input  logic        gb_wen,
    input  logic        gb_rstb,
    output logic [31:0] gb_rdata,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready
);
    localparam int              DEPTH    = 1 << DEPTH_LOG2;
    localparam int              CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    function automatic logic [7:0] cnt8(input logic [CW-1:0] c);
        cnt8 = 8'(c);
    endfunction

    logic        sel_s;
    logic [1:0]  off_s;
    logic        wr_data_s;
    logic        wr_ctrl_s;
    logic        wr_scr_s;
    logic        clr_sticky_s;

    assign sel_s        = (gb_addr[23:2] == BASE_ADDR[23:2]);
    assign off_s        = gb_addr[1:0];
    assign wr_data_s    = gb_wen && sel_s && (off_s == 2'd0);
    assign wr_ctrl_s    = gb_wen && sel_s && (off_s == 2'd2);
    assign wr_scr_s     = gb_wen && sel_s && (off_s == 2'd3);
    assign clr_sticky_s = wr_ctrl_s && gb_wdata[2];

    // ---------------- TX FIFO ----------------
    logic [31:0]           tx_mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_r;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_r;
    logic [CW-1:0]         tx_cnt_r;
    logic                  tx_ovf_r;
    logic                  tx_full_s;
    logic                  tx_empty_s;
    logic                  tx_push_s;
    logic                  tx_pop_s;
    logic                  tx_flush_s;

    assign tx_full_s  = (tx_cnt_r == FULL_CNT);
    assign tx_empty_s = (tx_cnt_r == CNT_ZERO);
    assign tx_push_s  = wr_data_s && !tx_full_s;
    assign tx_pop_s   = !tx_empty_s && m_ready;
    assign tx_flush_s = wr_ctrl_s && gb_wdata[0];
    assign m_valid    = !tx_empty_s;
    assign m_data     = tx_mem_r[tx_rd_ptr_r];

    // TX storage; a flushed push never lands so the head stays put
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= 32'h0000_0000;
        end else if (tx_push_s && !tx_flush_s) begin
            tx_mem_r[tx_wr_ptr_r] <= gb_wdata;
        end
    end

    // TX pointers, count and overflow sticky (set beats clear)
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            tx_rd_ptr_r <= PTR_ZERO;
            tx_wr_ptr_r <= PTR_ZERO;
            tx_cnt_r    <= CNT_ZERO;
            tx_ovf_r    <= 1'b0;
        end else begin
            if (tx_flush_s) begin
                tx_rd_ptr_r <= PTR_ZERO;
                tx_wr_ptr_r <= PTR_ZERO;
                tx_cnt_r    <= CNT_ZERO;
            end else begin
                if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
                if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
                tx_cnt_r <= tx_cnt_r + CW'(tx_push_s) - CW'(tx_pop_s);
            end
            tx_ovf_r <= (tx_ovf_r && !clr_sticky_s) || (wr_data_s && tx_full_s);
        end
    end

    // ---------------- RX FIFO (optional) ----------------
    logic [CW-1:0] rx_cnt_s;
    logic          rx_empty_s;
    logic          rx_unf_s;
    logic [31:0]   rx_head_s;

`ifdef GB_MAILBOX_RXFIFO_EN
    logic [31:0]           rx_mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_r;
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_r;
    logic [CW-1:0]         rx_cnt_r;
    logic                  rx_unf_r;
    logic                  rx_full_s;
    logic                  rd_data_s;
    logic                  rx_push_s;
    logic                  rx_pop_s;
    logic                  rx_flush_s;

    assign rx_full_s  = (rx_cnt_r == FULL_CNT);
    assign rx_empty_s = (rx_cnt_r == CNT_ZERO);
    assign rd_data_s  = gb_rstb && sel_s && (off_s == 2'd0);
    assign rx_push_s  = s_valid && !rx_full_s;
    assign rx_pop_s   = rd_data_s && !rx_empty_s;
    assign rx_flush_s = wr_ctrl_s && gb_wdata[1];
    assign s_ready    = !rx_full_s;
    assign rx_cnt_s   = rx_cnt_r;
    assign rx_unf_s   = rx_unf_r;
    assign rx_head_s  = rx_mem_r[rx_rd_ptr_r];

    // RX storage
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= 32'h0000_0000;
        end else if (rx_push_s && !rx_flush_s) begin
            rx_mem_r[rx_wr_ptr_r] <= s_data;
        end
    end

    // RX pointers, count and underflow sticky (set beats clear)
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            rx_rd_ptr_r <= PTR_ZERO;
            rx_wr_ptr_r <= PTR_ZERO;
            rx_cnt_r    <= CNT_ZERO;
            rx_unf_r    <= 1'b0;
        end else begin
            if (rx_flush_s) begin
                rx_rd_ptr_r <= PTR_ZERO;
                rx_wr_ptr_r <= PTR_ZERO;
                rx_cnt_r    <= CNT_ZERO;
            end else begin
                if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
                if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
                rx_cnt_r <= rx_cnt_r + CW'(rx_push_s) - CW'(rx_pop_s);
            end
            rx_unf_r <= (rx_unf_r && !clr_sticky_s) || (rd_data_s && rx_empty_s);
        end
    end
`else
    logic unused_rx_s;

    assign unused_rx_s = ^{s_data, s_valid};
    assign s_ready     = 1'b0;
    assign rx_cnt_s    = CNT_ZERO;
    assign rx_empty_s  = 1'b1;
    assign rx_unf_s    = 1'b0;
    assign rx_head_s   = 32'h0000_0000;
`endif

    // ---------------- register window ----------------
    logic [31:0] scratch_r;
    logic [31:0] status_s;
    logic [31:0] rd_val_s;

    assign status_s = {8'h00, cnt8(rx_cnt_s), cnt8(tx_cnt_r), 3'b000,
                       rx_unf_s, rx_empty_s, tx_ovf_r, tx_empty_s, tx_full_s};

    // Scratch register
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            scratch_r <= 32'h0000_0000;
        end else if (wr_scr_s) begin
            scratch_r <= gb_wdata;
        end
    end

    // Read mux from pre-edge state; unselected reads yield 0
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (sel_s) begin
            case (off_s)
                2'd0:    rd_val_s = rx_empty_s ? 32'h0000_0000 : rx_head_s;
                2'd1:    rd_val_s = status_s;
                2'd2:    rd_val_s = 32'h0000_0000;
                2'd3:    rd_val_s = scratch_r;
                default: rd_val_s = 32'h0000_0000;
            endcase
        end else begin
            rd_val_s = 32'h0000_0000;
        end
    end

    // Read data register, loaded only on a read strobe
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            gb_rdata <= 32'h0000_0000;
        end else if (gb_rstb) begin
            gb_rdata <= rd_val_s;
        end
    end
endmodule

// File: tb/tb_gb_mailbox.sv
// Randomized self-checking bench for gb_mailbox against a queue-based model of the mailbox.
module tb_gb_mailbox;
    localparam logic [23:0] BASE  = 24'h012344;
    localparam int          DEPTH = 16;
`ifdef GB_MAILBOX_RXFIFO_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        gb_clk = 1'b0;
    logic        gb_rst = 1'b1;
    logic [23:0] gb_addr = 24'h0;
    logic [31:0] gb_wdata = 32'h0;
    logic        gb_wen = 1'b0;
    logic        gb_rstb = 1'b0;
    logic [31:0] gb_rdata;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;

    gb_mailbox #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
    );

    always #5 gb_clk = ~gb_clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] scr_m = 32'h0;
    logic [31:0] rdata_m = 32'h0;
    bit          ovf_m = 1'b0;
    bit          unf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] status_m(input int txn, input int rxn);
        int v;
        v = (txn == DEPTH ? 1 : 0) + (txn == 0 ? 2 : 0) + (ovf_m ? 4 : 0)
          + (rxn == 0 ? 8 : 0) + (unf_m ? 16 : 0) + txn * 256 + rxn * 65536;
        return 32'(v);
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        scr_m = 32'h0; rdata_m = 32'h0; ovf_m = 1'b0; unf_m = 1'b0;
    endtask

    // One clock: advance the model from pre-edge state, take the edge, compare outputs.
    task automatic step();
        bit sel;
        logic [1:0] off;
        int txn, rxn;
        bit tx_ev, rx_ev;
        sel = (gb_addr[23:2] == BASE[23:2]);
        off = gb_addr[1:0];
        txn = tx_q.size();
        rxn = rx_q.size();
        if (gb_rstb) begin
            if (!sel) rdata_m = 32'h0;
            else begin
                case (off)
                    2'd0: rdata_m = (RX_EN && rxn > 0) ? rx_q[0] : 32'h0;
                    2'd1: rdata_m = status_m(txn, rxn);
                    2'd2: rdata_m = 32'h0;
                    default: rdata_m = scr_m;
                endcase
            end
        end
        tx_ev = gb_wen && sel && off == 2'd0 && txn == DEPTH;
        rx_ev = RX_EN && gb_rstb && sel && off == 2'd0 && rxn == 0;
        if (m_ready && txn > 0) tx_q.delete(0);
        if (gb_wen && sel && off == 2'd0 && txn < DEPTH) tx_q.push_back(gb_wdata);
        if (RX_EN) begin
            if (gb_rstb && sel && off == 2'd0 && rxn > 0) rx_q.delete(0);
            if (s_valid && rxn < DEPTH) rx_q.push_back(s_data);
        end
        if (gb_wen && sel && off == 2'd2) begin
            if (gb_wdata[0]) tx_q.delete();
            if (gb_wdata[1] && RX_EN) rx_q.delete();
            if (gb_wdata[2]) begin ovf_m = 1'b0; unf_m = 1'b0; end
        end
        if (tx_ev) ovf_m = 1'b1;
        if (rx_ev) unf_m = 1'b1;
        if (gb_wen && sel && off == 2'd3) scr_m = gb_wdata;
        @(posedge gb_clk);
        #1;
        chk("rdata", gb_rdata, rdata_m);
        chk("m_valid", {31'h0, m_valid}, {31'h0, tx_q.size() != 0});
        if (tx_q.size() != 0) chk("m_data", m_data, tx_q[0]);
        chk("s_ready", {31'h0, s_ready}, {31'h0, RX_EN && rx_q.size() < DEPTH});
    endtask

    task automatic cyc(input bit wen, input bit rstb, input logic [23:0] addr, input logic [31:0] wd);
        gb_wen = wen; gb_rstb = rstb; gb_addr = addr; gb_wdata = wd;
        step();
        gb_wen = 1'b0; gb_rstb = 1'b0;
    endtask

    logic [31:0] rst_exp [5];

    initial begin
        rst_exp[0] = 32'h0; rst_exp[1] = 32'h0000_000A; rst_exp[2] = 32'h0;
        rst_exp[3] = 32'h0; rst_exp[4] = 32'h0;

        // reset values
        repeat (3) @(posedge gb_clk);
        #1;
        chk("rst_rdata", gb_rdata, 32'h0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_s_ready", {31'h0, s_ready}, {31'h0, RX_EN});
        gb_rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, BASE + 24'(k), 32'h0);
            chk("rst_read", gb_rdata, rst_exp[k]);
        end

        // TX fill past full, then drain
        m_ready = 1'b0;
        for (int v = 1; v <= 17; v++) cyc(1'b1, 1'b0, BASE, 32'(v));
        cyc(1'b0, 1'b1, BASE + 24'd1, 32'h0);
        chk("status_full", gb_rdata, 32'h0000_100D);
        m_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            chk("drain_seq", m_data, 32'(v));
            cyc(1'b0, 1'b0, BASE, 32'h0);
        end
        chk("drain_empty", {31'h0, m_valid}, 32'h0);
        m_ready = 1'b0;
        cyc(1'b1, 1'b0, BASE + 24'd2, 32'h4);

        // scratch and unselected read
        cyc(1'b1, 1'b0, BASE + 24'd3, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, BASE + 24'd3, 32'h0);
        chk("scratch", gb_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, BASE, 32'h0);
        chk("rdata_hold", gb_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, BASE + 24'd8, 32'h0);
        chk("unsel_read", gb_rdata, 32'h0);

`ifdef GB_MAILBOX_RXFIFO_EN
        s_valid = 1'b1; s_data = 32'hC0; cyc(1'b0, 1'b0, BASE, 32'h0);
        s_data = 32'hC1; cyc(1'b0, 1'b0, BASE, 32'h0);
        s_valid = 1'b0;
        cyc(1'b0, 1'b1, BASE, 32'h0); chk("rx_c0", gb_rdata, 32'hC0);
        cyc(1'b0, 1'b1, BASE, 32'h0); chk("rx_c1", gb_rdata, 32'hC1);
        cyc(1'b0, 1'b1, BASE, 32'h0); chk("rx_unf_data", gb_rdata, 32'h0);
        cyc(1'b0, 1'b1, BASE + 24'd1, 32'h0); chk("rx_unf_set", {31'h0, gb_rdata[4]}, 32'h1);
        cyc(1'b1, 1'b0, BASE + 24'd2, 32'h4);
        cyc(1'b0, 1'b1, BASE + 24'd1, 32'h0); chk("rx_unf_clr", {31'h0, gb_rdata[4]}, 32'h0);
`else
        s_valid = 1'b1; s_data = 32'hC0;
        cyc(1'b0, 1'b0, BASE, 32'h0);
        chk("no_rx_ready", {31'h0, s_ready}, 32'h0);
        cyc(1'b0, 1'b1, BASE, 32'h0); chk("no_rx_data", gb_rdata, 32'h0);
        cyc(1'b0, 1'b1, BASE + 24'd1, 32'h0); chk("no_rx_stat", {30'h0, gb_rdata[4:3]}, 32'h1);
        s_valid = 1'b0;
`endif

        // flush with concurrent pop
        for (int v = 0; v < 3; v++) cyc(1'b1, 1'b0, BASE, 32'h100 + 32'(v));
        m_ready = 1'b1;
        cyc(1'b1, 1'b0, BASE + 24'd2, 32'h1);
        m_ready = 1'b0;
        chk("flush_valid", {31'h0, m_valid}, 32'h0);
        cyc(1'b0, 1'b1, BASE + 24'd1, 32'h0);
        chk("flush_cnt", {24'h0, gb_rdata[15:8]}, 32'h0);

        // reset mid-operation
        cyc(1'b1, 1'b0, BASE, 32'h55);
        cyc(1'b1, 1'b0, BASE, 32'h66);
        gb_rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, m_valid}, 32'h0);
        chk("midrst_rdata", gb_rdata, 32'h0);
        model_reset();
        @(posedge gb_clk); #1;
        gb_rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [23:0] a;
            r = int'($urandom_range(15, 0));
            if (r <= 6)       a = BASE;
            else if (r <= 10) a = BASE + 24'd1;
            else if (r == 11) a = BASE + 24'd2;
            else if (r <= 13) a = BASE + 24'd3;
            else if (r == 14) a = BASE + 24'd4 + 24'($urandom_range(3, 0));
            else              a = 24'($urandom);
            m_ready = (n < 1500) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            s_valid = $urandom_range(1, 0) == 1;
            s_data  = $urandom;
            gb_wen  = $urandom_range(9, 0) < 4;
            gb_rstb = $urandom_range(9, 0) < 4;
            gb_addr = a;
            gb_wdata = (a == BASE + 24'd2) ? 32'($urandom_range(7, 0)) : $urandom;
            step();
        end
        gb_wen = 1'b0; gb_rstb = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
